draw_scheduler: RTL and testbench

// - Initiator side of the graphing-unit plot/done handshake: once per frame, runs each enabled graphing unit in turn.
// - Pulses plot to one unit, forwards that unit's pixel stream (x, y, colour, writeEn) to the VGA adapter write port, and waits for its done.
// - Sits between the game controller (frame tick) and the VGA adapter; the only block allowed to drive the adapter.

---
 rtl/draw_scheduler_pkg.sv | 23 ++
 rtl/draw_pixel_mux.sv | 45 ++++
 rtl/draw_scheduler.sv | 162 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared types and widths for the draw scheduler and its pixel mux.
package draw_scheduler_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned C_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_FRAME_DONE
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/draw_pixel_mux.sv
// Registered NUM_GU:1 pixel mux feeding the VGA adapter write port.
module draw_pixel_mux
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned NUM_GU = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IDX_W-1:0]      i_sel,
  input  logic                  i_active,
  input  logic [NUM_GU*X_W-1:0] i_x,
  input  logic [NUM_GU*Y_W-1:0] i_y,
  input  logic [NUM_GU*C_W-1:0] i_colour,
  input  logic [NUM_GU-1:0]     i_we,
  output logic [X_W-1:0]        o_x,
  output logic [Y_W-1:0]        o_y,
  output logic [C_W-1:0]        o_colour,
  output logic                  o_we
);

  pixel_t r_pix;
  logic   r_we;

  // Sample the selected unit while a unit is being served; gate the strobe otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix <= '0;
      r_we  <= 1'b0;
    end else if (i_active) begin
      r_pix.x      <= i_x[int'(i_sel)*X_W +: X_W];
      r_pix.y      <= i_y[int'(i_sel)*Y_W +: Y_W];
      r_pix.colour <= i_colour[int'(i_sel)*C_W +: C_W];
      r_we         <= i_we[i_sel];
    end else begin
      r_we <= 1'b0;
    end
  end

  assign o_x      = r_pix.x;
  assign o_y      = r_pix.y;
  assign o_colour = r_pix.colour;
  assign o_we     = r_we;

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame plot/done initiator: serves each enabled graphing unit in priority order.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned NUM_GU         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_tick,
  input  logic [NUM_GU-1:0]     gu_enable,
  input  logic                  clr_err,
  output logic [NUM_GU-1:0]     gu_plot,
  input  logic [NUM_GU-1:0]     gu_done,
  input  logic [NUM_GU*X_W-1:0] gu_x,
  input  logic [NUM_GU*Y_W-1:0] gu_y,
  input  logic [NUM_GU*C_W-1:0] gu_colour,
  input  logic [NUM_GU-1:0]     gu_writeEn,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [C_W-1:0]        vga_colour,
  output logic                  vga_writeEn,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic                  overrun
);

  localparam int unsigned IDX_W = (NUM_GU > 1) ? $clog2(NUM_GU) : 1;
  localparam int unsigned SEL_W = $clog2(NUM_GU + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_GU-1:0] r_mask;
  logic [NUM_GU-1:0] r_plot;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pending;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_timeout_err;
  logic              r_overrun;

  logic [IDX_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_next_sel;
  logic              w_found;
  logic              w_done;
  logic              w_to_hit;
  logic              w_ovr_hit;
  logic              w_active;

  assign w_idx     = IDX_W'(r_sel);
  assign w_done    = gu_done[w_idx];
  assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_SETTLE);
  assign w_to_hit  = (r_state == S_WAIT) && !w_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_ovr_hit = frame_tick && (r_state != S_IDLE) && (r_state != S_FRAME_DONE);

  // Priority scan: lowest enabled unit index at or above the current selection.
  always_comb begin
    w_found    = 1'b0;
    w_next_sel = '0;
    for (int i = NUM_GU - 1; i >= 0; i--) begin
      if (r_mask[i] && (SEL_W'(i) >= r_sel)) begin
        w_found    = 1'b1;
        w_next_sel = SEL_W'(i);
      end
    end
  end

  // Pass sequencing, timeout counter, pending tick and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_sel         <= '0;
      r_mask        <= '0;
      r_plot        <= '0;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_plot        <= '0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= w_to_hit  | (r_timeout_err & ~clr_err);
      r_overrun     <= w_ovr_hit | (r_overrun & ~clr_err);
      if (frame_tick && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_tick || r_pending) begin
            r_mask    <= gu_enable;
            r_sel     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_sel   <= w_next_sel;
            r_plot  <= NUM_GU'(1) << w_next_sel;
            r_state <= S_ISSUE;
          end else begin
            r_frame_done <= 1'b1;
            r_state      <= S_FRAME_DONE;
          end
        end
        S_ISSUE: begin
          // r_cnt tracks cycles elapsed since the plot pulse.
          r_cnt   <= CNT_W'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done || w_to_hit) begin
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          r_sel   <= r_sel + SEL_W'(1);
          r_state <= S_SCAN;
        end
        S_FRAME_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  draw_pixel_mux #(
    .NUM_GU (NUM_GU),
    .IDX_W  (IDX_W)
  ) u_pixel_mux (
    .clk      (clk),
    .resetn   (resetn),
    .i_sel    (w_idx),
    .i_active (w_active),
    .i_x      (gu_x),
    .i_y      (gu_y),
    .i_colour (gu_colour),
    .i_we     (gu_writeEn),
    .o_x      (vga_x),
    .o_y      (vga_y),
    .o_colour (vga_colour),
    .o_we     (vga_writeEn)
  );

  assign gu_plot     = r_plot;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: unit models push expected pixels, a monitor pops and compares.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic [3:0]  gu_enable;
  logic        clr_err;
  logic [3:0]  gu_plot;
  logic [3:0]  gu_done;
  logic [35:0] gu_x;
  logic [31:0] gu_y;
  logic [11:0] gu_colour;
  logic [3:0]  gu_writeEn;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_writeEn;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic        overrun;

  draw_scheduler dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .gu_enable   (gu_enable),
    .clr_err     (clr_err),
    .gu_plot     (gu_plot),
    .gu_done     (gu_done),
    .gu_x        (gu_x),
    .gu_y        (gu_y),
    .gu_colour   (gu_colour),
    .gu_writeEn  (gu_writeEn),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_writeEn (vga_writeEn),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_pix    = 0;
  int fd_count = 0;

  logic [63:0] pix_q[$];
  logic [3:0]  plot_q[$];

  // Unit behaviour: 0 = 3-pixel writer, 1 = silent (never done), 2 = constant writeEn/done, 3 = endless stream
  logic [1:0]  u_mode[4];
  int          u_step[4];
  logic        m_we, m_dn;
  logic [19:0] m_p;
  logic [63:0] mon_e;
  logic [3:0]  mon_pq;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] pix(input int u, input int j);
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    x = 9'(16 + 64 * u + j);
    y = 8'(8 + 32 * u + j);
    c = 3'(1 + u + j);
    return {x, y, c};
  endfunction

  // Graphing-unit models; a value driven at the negedge of cycle m is the unit's cycle-m output.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      m_we = 1'b0;
      m_dn = 1'b0;
      m_p  = '0;
      if (!resetn) begin
        u_step[i] = 0;
      end else if (u_mode[i] == 2'd2) begin
        m_we = 1'b1;
        m_dn = 1'b1;
      end else if (u_step[i] > 0) begin
        if (u_mode[i] == 2'd0) begin
          if (u_step[i] <= 3) begin
            m_we = 1'b1;
            m_p  = pix(i, u_step[i] - 1);
          end else begin
            m_dn = 1'b1;
          end
          u_step[i] = (u_step[i] == 4) ? 0 : u_step[i] + 1;
        end else if (u_mode[i] == 2'd3) begin
          m_we = 1'b1;
          m_p  = pix(i, 0);
        end
      end
      if (resetn && gu_plot[i] && (u_mode[i] != 2'd2)) u_step[i] = 1;
      if (m_we && (u_mode[i] != 2'd2)) pix_q.push_back({12'd0, m_p, 32'(cyc + 1)});
      gu_writeEn[i]        = m_we;
      gu_done[i]           = m_dn;
      gu_x[i*9 +: 9]       = m_p[19:11];
      gu_y[i*8 +: 8]       = m_p[10:3];
      gu_colour[i*3 +: 3]  = m_p[2:0];
    end
  end

  // Monitor: every adapter write and every plot pulse must match the head of its queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (vga_writeEn) begin
        n_pix++;
        if (pix_q.size() == 0) begin
          chk("unexpected_pixel", 64'(vga_writeEn), 64'd0);
        end else begin
          mon_e = pix_q.pop_front();
          chk("pixel", {12'd0, vga_x, vga_y, vga_colour, 32'(cyc)}, mon_e);
        end
      end
      if (gu_plot != 4'd0) begin
        if (plot_q.size() == 0) begin
          chk("unexpected_plot", 64'(gu_plot), 64'd0);
        end else begin
          mon_pq = plot_q.pop_front();
          chk("plot", 64'(gu_plot), 64'(mon_pq));
        end
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic pulse_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic wait_fd(input int bound);
    int k;
    k = 0;
    while (!frame_done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done_seen", 64'(frame_done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    gu_enable  = 4'd0;
    clr_err    = 1'b0;
    for (int i = 0; i < 4; i++) u_mode[i] = 2'd0;
    u_mode[1] = 2'd2;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_plot", 64'(gu_plot), 64'd0);
    chk("rst_vga_we", 64'(vga_writeEn), 64'd0);
    chk("rst_vga_x", 64'(vga_x), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Mask 0101: units 0 then 2; unit 1 spams writeEn/done; mask change mid-pass ignored
    gu_enable = 4'b0101;
    plot_q.push_back(4'b0001);
    plot_q.push_back(4'b0100);
    pulse_tick();
    gu_enable = 4'b1111;
    wait_fd(200);
    chk("pass1_busy_at_done", 64'(busy), 64'd1);
    @(negedge clk);
    chk("pass1_fd_count", 64'(fd_count), 64'd1);
    chk("pass1_pixels", 64'(n_pix), 64'd6);
    chk("pass1_plots_left", 64'(plot_q.size()), 64'd0);
    chk("pass1_pix_left", 64'(pix_q.size()), 64'd0);
    chk("pass1_busy_after", 64'(busy), 64'd0);

    // Empty mask: frame_done 2 cycles after the tick, busy for 2 cycles
    u_mode[1] = 2'd1;
    gu_enable = 4'd0;
    pulse_tick();
    chk("empty_busy_c1", 64'(busy), 64'd1);
    chk("empty_fd_c1", 64'(frame_done), 64'd0);
    @(negedge clk);
    chk("empty_fd_c2", 64'(frame_done), 64'd1);
    chk("empty_busy_c2", 64'(busy), 64'd1);
    @(negedge clk);
    chk("empty_busy_c3", 64'(busy), 64'd0);
    chk("empty_fd_c3", 64'(frame_done), 64'd0);
    chk("empty_fd_count", 64'(fd_count), 64'd2);

    // Timeout: unit 1 never answers
    gu_enable = 4'b0010;
    plot_q.push_back(4'b0010);
    pulse_tick();
    @(negedge clk);
    chk("to_plot", 64'(gu_plot), 64'b0010);
    repeat (4095) @(negedge clk);
    chk("to_err_early", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("to_err_set", 64'(timeout_err), 64'd1);
    @(negedge clk);
    chk("to_fd_early", 64'(frame_done), 64'd0);
    @(negedge clk);
    chk("to_fd", 64'(frame_done), 64'd1);
    chk("to_no_overrun", 64'(overrun), 64'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_err_cleared", 64'(timeout_err), 64'd0);

    // Overrun: tick in WAIT, tick again (dropped); one extra pass right after frame_done
    gu_enable = 4'b0001;
    plot_q.push_back(4'b0001);
    plot_q.push_back(4'b0001);
    pulse_tick();
    repeat (3) @(negedge clk);
    chk("ovr_clear_before", 64'(overrun), 64'd0);
    pulse_tick();
    chk("ovr_set", 64'(overrun), 64'd1);
    pulse_tick();
    wait_fd(50);
    @(negedge clk);
    chk("ovr_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("ovr_second_pass", 64'(busy), 64'd1);
    wait_fd(100);
    repeat (20) @(negedge clk);
    chk("ovr_no_third", 64'(busy), 64'd0);
    chk("ovr_fd_count", 64'(fd_count), 64'd5);
    chk("ovr_plots_left", 64'(plot_q.size()), 64'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Asynchronous reset while unit 2 is streaming in WAIT
    u_mode[2] = 2'd3;
    gu_enable = 4'b0100;
    plot_q.push_back(4'b0100);
    pulse_tick();
    repeat (3) @(negedge clk);
    chk("rstmid_we_before", 64'(vga_writeEn), 64'd1);
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_we", 64'(vga_writeEn), 64'd0);
    chk("rstmid_plot", 64'(gu_plot), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    u_mode[2] = 2'd1;
    @(negedge clk);
    pix_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_idle_busy", 64'(busy), 64'd0);
    chk("rstmid_idle_we", 64'(vga_writeEn), 64'd0);

    // Recovery pass after reset
    gu_enable = 4'b0001;
    plot_q.push_back(4'b0001);
    pulse_tick();
    wait_fd(50);
    @(negedge clk);
    chk("recov_plots_left", 64'(plot_q.size()), 64'd0);
    chk("recov_pix_left", 64'(pix_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
